// File: rtl/aclk_pkg.sv
// Shared types and constants for the alarm-clock keypad scanner.
// Covers scan FSM states, key codes and the row/column-to-code map.
package aclk_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_e;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] key_lookup(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = KEY_A;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = KEY_B;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = 4'h0;
      4'hE: k = KEY_HASH;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/aclk_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle active-low lines read released.
module aclk_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/aclk_keypad_scan.sv
// 4x4 keypad scanner: column scan, press/release debounce, and one
// shift (digit) or func (non-digit) pulse per accepted press.
module aclk_keypad_scan
  import aclk_pkg::*;
#(
  parameter int SCAN_DIV     = 256,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key,
  output logic                shift,
  output logic                func
);
  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MATCH_W = $clog2(DEBOUNCE_CNT + 1);

  logic [NUM_ROWS-1:0] rs;
  aclk_sync2 #(.W(NUM_ROWS)) u_sync (.clk(clk), .reset(reset), .d(row), .q(rs));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [3:0]          key_q, key_d;
  logic                shift_q, shift_d, func_q, func_d;
  logic [NUM_COLS-1:0] col_q, col_d;

  logic       sample, rs_valid, match_done;
  logic [1:0] rs_idx;

  assign sample     = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign match_done = (match_q == MATCH_W'(DEBOUNCE_CNT - 1));

  // Exactly one low row is a usable sample; anything else is noise or a chord.
  always_comb begin
    rs_valid = 1'b1;
    rs_idx   = 2'd0;
    case (rs)
      4'b1110: rs_idx = 2'd0;
      4'b1101: rs_idx = 2'd1;
      4'b1011: rs_idx = 2'd2;
      4'b0111: rs_idx = 2'd3;
      default: rs_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = sample ? '0 : cnt_q + CNT_W'(1);
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    match_d   = match_q;
    key_d     = key_q;
    shift_d   = 1'b0;
    func_d    = 1'b0;
    case (state_q)
      SCAN: if (sample) begin
        if (rs_valid) begin
          row_idx_d = rs_idx;
          match_d   = MATCH_W'(1);
          state_d   = DEBOUNCE;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      DEBOUNCE: if (sample) begin
        if (rs_valid && rs_idx == row_idx_q) begin
          if (match_done) begin
            key_d   = key_lookup(col_idx_q, row_idx_q);
            shift_d = is_digit(key_d);
            func_d  = !is_digit(key_d);
            match_d = '0;
            state_d = EMIT;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end
      // match doubles as the consecutive-release counter here
      WAIT_RELEASE: if (sample) begin
        if (rs == 4'b1111) begin
          if (match_done) begin
            match_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
    col_d = ~(NUM_COLS'(1) << col_idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      match_q   <= '0;
      key_q     <= 4'd0;
      shift_q   <= 1'b0;
      func_q    <= 1'b0;
      col_q     <= 4'b1110;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      match_q   <= match_d;
      key_q     <= key_d;
      shift_q   <= shift_d;
      func_q    <= func_d;
      col_q     <= col_d;
    end
  end

  assign col   = col_q;
  assign key   = key_q;
  assign shift = shift_q;
  assign func  = func_q;
endmodule

// File: tb/tb_aclk_keypad_scan.sv
// Keypad scanner bench: a physical keypad model drives rows from the DUT's
// columns; pulses are collected and compared against the key map.
module tb_aclk_keypad_scan;
  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key;
  logic       shift, func;

  logic [15:0] pressed = '0;   // bit r*4+c = switch at row r / column c closed
  logic [4:0]  pq[$];          // observed pulses as {func, key}
  logic [15:0] dstream = '0;   // downstream key-buffer: {ms_hr, ls_hr, ms_min, ls_min}
  int errors = 0;
  int checks = 0;

  int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  aclk_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk), .reset(rst_n), .row(row), .col(col), .key(key), .shift(shift), .func(func)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && (shift || func)) begin
      checks++;
      assert (!(shift && func)) else begin
        errors++;
        $error("FAIL excl observed shift=%0b func=%0b expected one", shift, func);
      end
      pq.push_back({func, key});
      if (shift) dstream = {dstream[11:0], key};
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (col !== c && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (col !== c) chk("wait_col", int'(col), int'(c));
  endtask

  task automatic press_release(input int r, input int c, input int hold, input int gap);
    pressed = 16'(1) << (r*4 + c);
    repeat (hold) @(negedge clk);
    pressed = '0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int exp_pulse(input int r, input int c);
    return (kmap[r][c] >= 10 ? 16 : 0) + kmap[r][c];
  endfunction

  function automatic int first_pulse();
    return (pq.size() == 0) ? -1 : int'(pq[0]);
  endfunction

  initial begin
    int n, r, c;
    // reset state and column rotation
    repeat (3) @(negedge clk);
    chk("rst_col", int'(col), 4'b1110);
    chk("rst_key", int'(key), 0);
    chk("rst_shift", int'(shift), 0);
    chk("rst_func", int'(func), 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      chk("rotate", int'(col), int'(~(4'b0001 << ((k / SD) % 4)) & 4'hF));
      @(negedge clk);
    end

    // reset while debouncing "3": no pulse, key stays 0
    wait_col(4'b1011);
    pq.delete();
    pressed = 16'(1) << 2;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_col", int'(col), 4'b1110);
    chk("midrst_key", int'(key), 0);
    chk("midrst_shift", int'(shift), 0);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_pulses", pq.size(), 0);
    chk("midrst_key2", int'(key), 0);

    // "5" held 200 clocks: exact latency and a single pulse
    wait_col(4'b1101);
    pq.delete();
    pressed = 16'(1) << 5;
    n = 0;
    while (!shift && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("k5_latency", n, 3 * SD);
    repeat (200 - n) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    chk("k5_count", pq.size(), 1);
    chk("k5_val", first_pulse(), 5);

    // "#" gives func only
    pq.delete();
    press_release(3, 2, 60, 40);
    chk("hash_count", pq.size(), 1);
    chk("hash_val", first_pulse(), 16 + 15);

    // r0 and r1 together in c0: rejected
    pq.delete();
    pressed = 16'h0011;
    repeat (80) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    chk("chord_count", pq.size(), 0);

    // bouncing "7" never reaches the debounce count
    pq.delete();
    pressed = 16'(1) << 8;
    repeat (SD) @(negedge clk);
    pressed = '0;
    repeat (SD) @(negedge clk);
    pressed = 16'(1) << 8;
    repeat (2 * SD) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    chk("bounce_count", pq.size(), 0);
    press_release(2, 0, 60, 40);
    chk("k7_count", pq.size(), 1);
    chk("k7_val", first_pulse(), 7);

    // 1,2,3,4 into the downstream key buffer
    pq.delete();
    press_release(0, 0, 60, 40);
    press_release(0, 1, 60, 40);
    press_release(0, 2, 60, 40);
    press_release(1, 0, 60, 40);
    chk("seq_count", pq.size(), 4);
    chk("ms_hr", int'(dstream[15:12]), 1);
    chk("ls_hr", int'(dstream[11:8]), 2);
    chk("ms_min", int'(dstream[7:4]), 3);
    chk("ls_min", int'(dstream[3:0]), 4);

    // random keys with random hold and release times
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pq.delete();
      press_release(r, c, $urandom_range(50, 90), $urandom_range(35, 60));
      chk("rnd_count", pq.size(), 1);
      chk("rnd_val", first_pulse(), exp_pulse(r, c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
